// File: rtl/uart_loanio_xcvr_if.sv
// Stream and status bundle between a UART client and uart_loanio_xcvr.
// rx_parity_err exists only when UART_PARITY_EN is defined.
interface uart_loanio_xcvr_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 err_clr;
  logic                 rx_overrun;
  logic                 rx_frame_err;
`ifdef UART_PARITY_EN
  logic                 rx_parity_err;

  modport master (output tx_data, tx_valid, rx_ready, err_clr,
                  input  tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err);
  modport slave  (input  tx_data, tx_valid, rx_ready, err_clr,
                  output tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err);
`else
  modport master (output tx_data, tx_valid, rx_ready, err_clr,
                  input  tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err);
  modport slave  (input  tx_data, tx_valid, rx_ready, err_clr,
                  output tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err);
`endif
endinterface

// File: rtl/uart_loanio_xcvr.sv
// Full-duplex UART on HPS loan-IO pins with TX/RX FIFOs, glitch-rejecting RX and sticky errors.
// Define UART_PARITY_EN to add an even-parity bit per frame and the rx_parity_err flag.
module uart_loanio_xcvr #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TX_PIN     = 49,
  parameter int RX_PIN     = 50
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  uart_loanio_xcvr_if.slave  bus,
  input  logic [66:0]        loan_io_in,
  output logic [66:0]        loan_io_out,
  output logic [66:0]        loan_io_oe
);
  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_WAIT} state_e;

  function automatic logic fifo_full_f(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  function automatic logic even_par_f(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Reset synchroniser: asserts asynchronously, releases on the clock
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) rst_sync_r <= 2'b00;
    else                rst_sync_r <= {rst_sync_r[0], 1'b1};
  assign rst_n_s = rst_sync_r[1];

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_mem_r [FIFO_DEPTH];
  logic [AW:0]          tx_wp_r, tx_rp_r, tx_wp_nx_s, tx_rp_nx_s;
  logic                 tx_ready_r, tx_push_s, tx_pop_s, tx_empty_s, tx_end_s;
  logic                 tx_par_r, tx_line_r;
  logic [DATA_BITS-1:0] tx_sh_r;
  logic [CW-1:0]        tx_cnt_r;
  logic [BW-1:0]        tx_bit_r;
  state_e               tx_state_r, tx_state_nx_s;

  assign tx_push_s  = bus.tx_valid && tx_ready_r;
  assign tx_empty_s = (tx_wp_r == tx_rp_r);
  assign tx_end_s   = (tx_cnt_r == DIV_END);
  assign tx_wp_nx_s = tx_wp_r + {{AW{1'b0}}, tx_push_s};
  assign tx_rp_nx_s = tx_rp_r + {{AW{1'b0}}, tx_pop_s};
  assign bus.tx_ready = tx_ready_r;

  // TX FIFO storage; occupancy is defined by the pointers alone
  always_ff @(posedge clk_clk)
    if (tx_push_s) tx_mem_r[tx_wp_r[AW-1:0]] <= bus.tx_data;

  // TX pointers; ready is registered from the post-update occupancy
  always_ff @(posedge clk_clk or negedge rst_n_s)
    if (!rst_n_s) begin
      tx_wp_r    <= {(AW+1){1'b0}};
      tx_rp_r    <= {(AW+1){1'b0}};
      tx_ready_r <= 1'b0;
    end else begin
      tx_wp_r    <= tx_wp_nx_s;
      tx_rp_r    <= tx_rp_nx_s;
      tx_ready_r <= !fifo_full_f(tx_wp_nx_s, tx_rp_nx_s);
    end

  // TX next-state; STOP chains straight into START when more data is queued
  always_comb begin
    tx_state_nx_s = tx_state_r;
    tx_pop_s      = 1'b0;
    case (tx_state_r)
      ST_IDLE:  if (!tx_empty_s) begin tx_pop_s = 1'b1; tx_state_nx_s = ST_START; end
                else tx_state_nx_s = ST_IDLE;
      ST_START: if (tx_end_s) tx_state_nx_s = ST_DATA; else tx_state_nx_s = ST_START;
      ST_DATA:  if (tx_end_s && tx_bit_r == LAST_BIT) tx_state_nx_s = PAR_EN ? ST_PAR : ST_STOP;
                else tx_state_nx_s = ST_DATA;
      ST_PAR:   if (tx_end_s) tx_state_nx_s = ST_STOP; else tx_state_nx_s = ST_PAR;
      ST_STOP:  if (tx_end_s && !tx_empty_s) begin tx_pop_s = 1'b1; tx_state_nx_s = ST_START; end
                else if (tx_end_s) tx_state_nx_s = ST_IDLE;
                else tx_state_nx_s = ST_STOP;
      default:  tx_state_nx_s = ST_IDLE;
    endcase
  end

  // TX datapath; the line register trails the state by one clock
  always_ff @(posedge clk_clk or negedge rst_n_s)
    if (!rst_n_s) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= {CW{1'b0}};
      tx_bit_r   <= {BW{1'b0}};
      tx_sh_r    <= {DATA_BITS{1'b0}};
      tx_par_r   <= 1'b0;
      tx_line_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nx_s;
      tx_cnt_r   <= (tx_state_r == ST_IDLE || tx_end_s) ? {CW{1'b0}} : tx_cnt_r + CW'(1'b1);
      if (tx_state_r != ST_DATA) tx_bit_r <= {BW{1'b0}};
      else if (tx_end_s)         tx_bit_r <= tx_bit_r + BW'(1'b1);
      if (tx_pop_s) begin
        tx_sh_r  <= tx_mem_r[tx_rp_r[AW-1:0]];
        tx_par_r <= even_par_f(tx_mem_r[tx_rp_r[AW-1:0]]);
      end else if (tx_state_r == ST_DATA && tx_end_s) begin
        tx_sh_r  <= tx_sh_r >> 1;
      end
      case (tx_state_r)
        ST_START: tx_line_r <= 1'b0;
        ST_DATA:  tx_line_r <= tx_sh_r[0];
        ST_PAR:   tx_line_r <= tx_par_r;
        default:  tx_line_r <= 1'b1;
      endcase
    end

  // ---------------- RX path ----------------
  logic [1:0]           rx_sync_r;
  logic                 rx_s, rx_end_s, rx_done_s, rx_push_s, rx_wr_s, rx_pop_s, rx_valid_s, rx_full_s;
  logic [DATA_BITS-1:0] rx_mem_r [FIFO_DEPTH];
  logic [AW:0]          rx_wp_r, rx_rp_r;
  logic [DATA_BITS-1:0] rx_sh_r;
  logic [CW-1:0]        rx_cnt_r;
  logic [BW-1:0]        rx_bit_r;
  logic                 rx_pbad_r, rx_overrun_r, rx_frame_err_r;
  state_e               rx_state_r, rx_state_nx_s;
  logic                 unused_s;

  assign rx_s       = rx_sync_r[1];
  assign rx_end_s   = (rx_cnt_r == DIV_END);
  assign rx_done_s  = (rx_state_r == ST_STOP) && rx_end_s;
  assign rx_push_s  = rx_done_s && rx_s;
  assign rx_valid_s = (rx_wp_r != rx_rp_r);
  assign rx_full_s  = fifo_full_f(rx_wp_r, rx_rp_r);
  assign rx_pop_s   = rx_valid_s && bus.rx_ready;
  assign rx_wr_s    = rx_push_s && (!rx_full_s || rx_pop_s);
  assign unused_s   = ^(loan_io_in & ~(67'd1 << RX_PIN));

  // RX line synchroniser, idling high
  always_ff @(posedge clk_clk or negedge rst_n_s)
    if (!rst_n_s) rx_sync_r <= 2'b11;
    else          rx_sync_r <= {rx_sync_r[0], loan_io_in[RX_PIN]};

  // RX next-state; a start bit must still be low at half a bit period
  always_comb begin
    rx_state_nx_s = rx_state_r;
    case (rx_state_r)
      ST_IDLE:  if (!rx_s) rx_state_nx_s = ST_START; else rx_state_nx_s = ST_IDLE;
      ST_START: if (rx_cnt_r == HALF_END) rx_state_nx_s = rx_s ? ST_IDLE : ST_DATA;
                else rx_state_nx_s = ST_START;
      ST_DATA:  if (rx_end_s && rx_bit_r == LAST_BIT) rx_state_nx_s = PAR_EN ? ST_PAR : ST_STOP;
                else rx_state_nx_s = ST_DATA;
      ST_PAR:   if (rx_end_s) rx_state_nx_s = ST_STOP; else rx_state_nx_s = ST_PAR;
      ST_STOP:  if (rx_end_s) rx_state_nx_s = rx_s ? ST_IDLE : ST_WAIT;
                else rx_state_nx_s = ST_STOP;
      ST_WAIT:  if (rx_s) rx_state_nx_s = ST_IDLE; else rx_state_nx_s = ST_WAIT;
      default:  rx_state_nx_s = ST_IDLE;
    endcase
  end

  // RX bit timing and deserialiser
  always_ff @(posedge clk_clk or negedge rst_n_s)
    if (!rst_n_s) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= {CW{1'b0}};
      rx_bit_r   <= {BW{1'b0}};
      rx_sh_r    <= {DATA_BITS{1'b0}};
      rx_pbad_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_state_nx_s;
      rx_cnt_r   <= (rx_state_nx_s != rx_state_r || rx_end_s) ? {CW{1'b0}} : rx_cnt_r + CW'(1'b1);
      if (rx_state_r != ST_DATA) rx_bit_r <= {BW{1'b0}};
      else if (rx_end_s)         rx_bit_r <= rx_bit_r + BW'(1'b1);
      if (rx_state_r == ST_DATA && rx_end_s) rx_sh_r <= {rx_s, rx_sh_r[DATA_BITS-1:1]};
      if (rx_state_r == ST_PAR && rx_end_s)  rx_pbad_r <= rx_s ^ even_par_f(rx_sh_r);
    end

  // RX FIFO storage; a full FIFO only accepts when its head leaves the same cycle
  always_ff @(posedge clk_clk)
    if (rx_wr_s) rx_mem_r[rx_wp_r[AW-1:0]] <= rx_sh_r;

  // RX pointers and sticky flags; a set event beats err_clr
  always_ff @(posedge clk_clk or negedge rst_n_s)
    if (!rst_n_s) begin
      rx_wp_r        <= {(AW+1){1'b0}};
      rx_rp_r        <= {(AW+1){1'b0}};
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      rx_wp_r        <= rx_wp_r + {{AW{1'b0}}, rx_wr_s};
      rx_rp_r        <= rx_rp_r + {{AW{1'b0}}, rx_pop_s};
      rx_overrun_r   <= (rx_push_s && rx_full_s && !rx_pop_s) || (rx_overrun_r && !bus.err_clr);
      rx_frame_err_r <= (rx_done_s && !rx_s) || (rx_frame_err_r && !bus.err_clr);
    end

`ifdef UART_PARITY_EN
  logic rx_parity_err_r;
  // Sticky parity flag; the byte itself is still delivered
  always_ff @(posedge clk_clk or negedge rst_n_s)
    if (!rst_n_s) rx_parity_err_r <= 1'b0;
    else          rx_parity_err_r <= (rx_done_s && rx_pbad_r) || (rx_parity_err_r && !bus.err_clr);
  assign bus.rx_parity_err = rx_parity_err_r;
`endif

  assign bus.rx_data      = rx_mem_r[rx_rp_r[AW-1:0]];
  assign bus.rx_valid     = rx_valid_s;
  assign bus.rx_overrun   = rx_overrun_r;
  assign bus.rx_frame_err = rx_frame_err_r;

  // Only the TX pin is ever driven
  always_comb begin
    loan_io_out         = 67'd0;
    loan_io_out[TX_PIN] = tx_line_r;
    loan_io_oe          = 67'd0;
    loan_io_oe[TX_PIN]  = 1'b1;
  end
endmodule
